// File: rtl/upc_pkg.sv
// Shared types and request decode for the micro-program sequencer.
// The decode maps the active-low request pins onto one operation by fixed priority.
package upc_pkg;

  typedef enum logic [2:0] {
    UPC_HOLD = 3'd0,
    UPC_CLR  = 3'd1,
    UPC_RET  = 3'd2,
    UPC_CALL = 3'd3,
    UPC_JMP  = 3'd4,
    UPC_INC  = 3'd5
  } upc_op_t;

  // Priority: HALT#/WS# freeze, then END#/ENDEXT#, RET#, CALL#, JMP#, else increment.
  function automatic upc_op_t upc_decode(
    input logic nend,
    input logic nendext,
    input logic nws,
    input logic nhalt,
    input logic njmp,
    input logic ncall,
    input logic nret
  );
    upc_op_t op;
    if (!nhalt || !nws) begin
      op = UPC_HOLD;
    end else if (!nend || !nendext) begin
      op = UPC_CLR;
    end else if (!nret) begin
      op = UPC_RET;
    end else if (!ncall) begin
      op = UPC_CALL;
    end else if (!njmp) begin
      op = UPC_JMP;
    end else begin
      op = UPC_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/upc_stack.sv
// Return-address LIFO for micro-subroutine calls.
// Push when full and pop when empty leave the stack untouched; the parent raises the flags.
module upc_stack
  import upc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk4,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_depth == DW'(DEPTH));
  assign empty     = (r_depth == '0);
  assign depth     = r_depth;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Occupancy counter; reset and clear both empty the stack.
  always_ff @(posedge clk4) begin
    if (reset) begin
      r_depth <= '0;
    end else if (clr) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end else begin
      r_depth <= r_depth;
    end
  end

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(posedge clk4) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && !clr && w_do_push && (r_depth == DW'(i))) begin
        r_mem[i] <= din;
      end else begin
        r_mem[i] <= r_mem[i];
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) begin
        top = r_mem[i];
      end else begin
        top = top;
      end
    end
  end

endmodule

// File: rtl/upc_seq.sv
// Micro-program sequencer: registered micro-address with clear, jump, call/return
// and increment, plus sticky stack overflow/underflow flags.
module upc_seq
  import upc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk4,
  input  logic             reset,
  input  logic             nend,
  input  logic             nendext,
  input  logic             nws,
  input  logic             nhalt,
  input  logic             njmp,
  input  logic             ncall,
  input  logic             nret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] upc,
  output logic [DW-1:0]    depth,
  output logic             ovf,
  output logic             unf,
  output logic             tc
);

  logic [WIDTH-1:0] r_upc;
  logic             r_ovf;
  logic             r_unf;
  upc_op_t          w_op;
  logic [WIDTH-1:0] w_upc_nxt;
  logic [WIDTH-1:0] w_upc_inc;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_op      = upc_decode(nend, nendext, nws, nhalt, njmp, ncall, nret);
  assign w_upc_inc = r_upc + WIDTH'(1);

  upc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk4  (clk4),
    .reset (reset),
    .clr   (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_upc_inc),
    .top   (w_top),
    .depth (depth),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next-address mux and stack/flag side effects for the decoded operation.
  always_comb begin
    w_upc_nxt = r_upc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clr     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      UPC_HOLD: w_upc_nxt = r_upc;
      UPC_CLR: begin
        w_upc_nxt = '0;
        w_clr     = 1'b1;
      end
      UPC_RET: begin
        if (!w_empty) begin
          w_upc_nxt = w_top;
          w_pop     = 1'b1;
        end else begin
          w_upc_nxt = '0;
          w_unf_set = 1'b1;
        end
      end
      UPC_CALL: begin
        if (!w_full) begin
          w_upc_nxt = target;
          w_push    = 1'b1;
        end else begin
          w_upc_nxt = w_upc_inc;
          w_ovf_set = 1'b1;
        end
      end
      UPC_JMP: w_upc_nxt = target;
      UPC_INC: w_upc_nxt = w_upc_inc;
      default: w_upc_nxt = r_upc;
    endcase
  end

  // Address and sticky flags; only reset clears the flags.
  always_ff @(posedge clk4) begin
    if (reset) begin
      r_upc <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_upc <= w_upc_nxt;
      r_ovf <= r_ovf | w_ovf_set;
      r_unf <= r_unf | w_unf_set;
    end
  end

  assign upc = r_upc;
  assign ovf = r_ovf;
  assign unf = r_unf;
  assign tc  = (r_upc == '1) && (w_op == UPC_INC);

endmodule

// File: tb/tb_upc_seq.sv
// Scoreboard bench for upc_seq: directed scenarios then random requests, checked
// against a queue-based behavioural model of the sequencer.
module tb_upc_seq;

  localparam int W   = 4;
  localparam int D   = 2;
  localparam int DWB = $clog2(D + 1);
  localparam int MOD = 1 << W;

  typedef struct {
    int upc;
    int depth;
    bit ovf;
    bit unf;
  } exp_t;

  logic           clk4 = 1'b0;
  logic           reset = 1'b1;
  logic           nend = 1'b1, nendext = 1'b1, nws = 1'b1, nhalt = 1'b1;
  logic           njmp = 1'b1, ncall = 1'b1, nret = 1'b1;
  logic [W-1:0]   target = '0;
  logic [W-1:0]   upc;
  logic [DWB-1:0] depth;
  logic           ovf, unf, tc;

  upc_seq #(.WIDTH(W), .DEPTH(D)) dut (
    .clk4(clk4), .reset(reset), .nend(nend), .nendext(nendext), .nws(nws),
    .nhalt(nhalt), .njmp(njmp), .ncall(ncall), .nret(nret), .target(target),
    .upc(upc), .depth(depth), .ovf(ovf), .unf(unf), .tc(tc)
  );

  always #5 clk4 = ~clk4;

  // Reference model state
  int   m_upc = 0;
  int   m_stk[$];
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;
  exp_t exp_q[$];
  bit   tc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step(input bit rst, input bit e, input bit ee, input bit ws,
                      input bit h, input bit j, input bit c, input bit r, input int tgt);
    bit   hold;
    exp_t x;
    @(negedge clk4);
    reset = rst; nend = e; nendext = ee; nws = ws; nhalt = h;
    njmp = j; ncall = c; nret = r; target = W'(tgt);
    hold = !h || !ws;
    tc_q.push_back((m_upc == MOD - 1) && !hold && e && ee && r && c && j);
    if (rst) begin
      m_upc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (hold) begin
      m_upc = m_upc;
    end else if (!e || !ee) begin
      m_upc = 0; m_stk.delete();
    end else if (!r) begin
      if (m_stk.size() > 0) m_upc = m_stk.pop_back();
      else begin m_upc = 0; m_unf = 1'b1; end
    end else if (!c) begin
      if (m_stk.size() < D) begin
        m_stk.push_back((m_upc + 1) % MOD);
        m_upc = tgt;
      end else begin
        m_upc = (m_upc + 1) % MOD; m_ovf = 1'b1;
      end
    end else if (!j) begin
      m_upc = tgt;
    end else begin
      m_upc = (m_upc + 1) % MOD;
    end
    x.upc = m_upc; x.depth = m_stk.size(); x.ovf = m_ovf; x.unf = m_unf;
    exp_q.push_back(x);
  endtask

  task automatic idle();          step(1'b0, 1, 1, 1, 1, 1, 1, 1, 0); endtask
  task automatic do_rst();        step(1'b1, 1, 1, 1, 1, 1, 1, 1, 0); endtask
  task automatic do_call(int t);  step(1'b0, 1, 1, 1, 1, 1, 0, 1, t); endtask
  task automatic do_ret();        step(1'b0, 1, 1, 1, 1, 1, 1, 0, 0); endtask

  task automatic run_until(input int v);
    for (int k = 0; k < 2 * MOD && m_upc != v; k++) idle();
  endtask

  // Monitor: tc checked mid-cycle against current inputs, state checked after each edge.
  initial begin
    exp_t x;
    bit   t;
    forever begin
      @(negedge clk4);
      #1;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        n_cmp++;
        if (tc !== t) begin
          n_bad++;
          $display("FAIL tc @%0t: got %0b expected %0b (upc=%0d)", $time, tc, t, upc);
        end
      end
      @(posedge clk4);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_cmp++;
        if (upc !== W'(x.upc) || depth !== DWB'(x.depth) || ovf !== x.ovf || unf !== x.unf) begin
          n_bad++;
          $display("FAIL state @%0t: got upc=%0d depth=%0d ovf=%0b unf=%0b expected upc=%0d depth=%0d ovf=%0b unf=%0b",
                   $time, upc, depth, ovf, unf, x.upc, x.depth, x.ovf, x.unf);
        end
      end
    end
  end

  initial begin
    do_rst();
    do_rst();
    repeat (20) idle();
    // END# under wait state is deferred to the first unheld edge
    run_until(5);
    step(1'b0, 0, 1, 0, 1, 1, 1, 1, 0);
    step(1'b0, 0, 1, 1, 1, 1, 1, 1, 0);
    // nested calls and returns
    do_rst();
    run_until(2);
    do_call(8);
    idle();
    do_call(12);
    do_ret();
    do_ret();
    // overflow, then underflow
    do_call(8);
    do_call(12);
    do_call(1);
    do_ret();
    do_ret();
    do_ret();
    repeat (3) idle();
    // reset during hold with a full stack and flags set
    do_call(5);
    do_call(6);
    step(1'b1, 1, 1, 1, 0, 1, 1, 1, 0);
    // simultaneous requests
    run_until(4);
    step(1'b0, 1, 1, 1, 1, 0, 0, 1, 9);
    step(1'b0, 0, 1, 1, 1, 1, 1, 0, 0);
    idle();
    // randomized requests
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 9) != 0),  ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) != 0),  ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 5) != 0),  $urandom_range(0, MOD - 1));
    end
    for (int k = 0; k < 8 && (exp_q.size() > 0 || tc_q.size() > 0); k++) begin
      @(posedge clk4);
      #2;
    end
    if (exp_q.size() > 0 || tc_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d state and %0d tc entries left, expected 0", exp_q.size(), tc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
